fu_issue_arbiter: RTL and testbench

Issue-select scheduler for the unified issue queue (16-entry RS, 3 FUs).
- Each cycle it takes the RS "ready" vector (valid and both sources ready) and each entry's assigned FU number.
- It grants at most one entry per FU, using a per-FU round-robin pointer.
- It tracks occupancy of the multi-cycle memory FU and returns a registered grant mask so the RS can clear issued entries.

---
 rtl/fu_issue_arbiter.sv | 143 ++++++++++++++
 tb/tb_fu_issue_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: per-FU round-robin issue select for a unified RS.
// Grants at most one ready entry per FU each cycle, masks entries granted
// in the previous cycle (the RS clears them one edge later), tracks the
// occupancy of the non-pipelined memory FU and flags bad FU numbers.
module fu_issue_arbiter #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX   = 4,
  parameter int FU_SIZE  = 2,
  parameter int FU_ARRAY = 3,
  parameter int MEM_FU   = 2,
  parameter int MEM_LAT  = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [RS_SIZE-1:0]           req_valid_in,
  input  logic [RS_SIZE*FU_SIZE-1:0]   req_fu_in,
  input  logic [FU_ARRAY-1:0]          fu_ready_from_FU_in,
  input  logic                         flush_in,
  output logic [FU_ARRAY-1:0]          grant_valid_out,
  output logic [FU_ARRAY*RS_IDX-1:0]   grant_idx_out,
  output logic [RS_SIZE-1:0]           grant_vec_out,
  output logic [1:0]                   issue_count_out,
  output logic                         no_issue_out,
  output logic                         mem_busy_out,
  output logic                         bad_fu_err_out
);

  localparam int BUSY_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [RS_IDX-1:0]   rr_ptr_r [FU_ARRAY];
  logic [BUSY_W-1:0]   busy_cnt_r;
  logic [BUSY_W-1:0]   busy_nxt_s;
  logic [RS_SIZE-1:0]  elig_s   [FU_ARRAY];
  logic [FU_ARRAY-1:0] sel_valid_s;
  logic [RS_IDX-1:0]   sel_idx_s [FU_ARRAY];
  logic [RS_SIZE-1:0]  sel_vec_s;
  logic                bad_s;

  // Number of FUs granted in one cycle.
  function automatic logic [1:0] count_ones(input logic [FU_ARRAY-1:0] v);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < FU_ARRAY; i++) begin
      cnt = cnt + {1'b0, v[i]};
    end
    return cnt;
  endfunction

  // Per-FU eligibility; entries with an out-of-range FU number match no FU.
  always_comb begin
    bad_s = 1'b0;
    for (int f = 0; f < FU_ARRAY; f++) begin
      for (int e = 0; e < RS_SIZE; e++) begin
        elig_s[f][e] = req_valid_in[e] && !grant_vec_out[e] &&
                       ({1'b0, req_fu_in[e*FU_SIZE +: FU_SIZE]} == (FU_SIZE+1)'(f));
      end
    end
    for (int e = 0; e < RS_SIZE; e++) begin
      if (req_valid_in[e] &&
          ({1'b0, req_fu_in[e*FU_SIZE +: FU_SIZE]} >= (FU_SIZE+1)'(FU_ARRAY))) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // Round-robin scan from each FU's pointer, wrapping modulo RS_SIZE.
  always_comb begin
    sel_valid_s = {FU_ARRAY{1'b0}};
    sel_vec_s   = {RS_SIZE{1'b0}};
    for (int f = 0; f < FU_ARRAY; f++) begin
      sel_idx_s[f] = {RS_IDX{1'b0}};
      for (int k = 0; k < RS_SIZE; k++) begin
        if (fu_ready_from_FU_in[f] &&
            ((f != MEM_FU) || (busy_cnt_r == {BUSY_W{1'b0}})) &&
            !sel_valid_s[f] && elig_s[f][rr_ptr_r[f] + RS_IDX'(k)]) begin
          sel_valid_s[f] = 1'b1;
          sel_idx_s[f]   = rr_ptr_r[f] + RS_IDX'(k);
        end else begin
          sel_valid_s[f] = sel_valid_s[f];
        end
      end
      if (sel_valid_s[f]) begin
        sel_vec_s[sel_idx_s[f]] = 1'b1;
      end else begin
        sel_vec_s = sel_vec_s;
      end
    end
  end

  // Memory FU occupancy: reload on grant, otherwise count down to zero.
  always_comb begin
    if (sel_valid_s[MEM_FU]) begin
      busy_nxt_s = BUSY_W'(MEM_LAT - 1);
    end else if (busy_cnt_r != {BUSY_W{1'b0}}) begin
      busy_nxt_s = busy_cnt_r - BUSY_W'(1);
    end else begin
      busy_nxt_s = busy_cnt_r;
    end
  end

  // Registered grants, pointers, occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_valid_out <= {FU_ARRAY{1'b0}};
      grant_idx_out   <= {(FU_ARRAY*RS_IDX){1'b0}};
      grant_vec_out   <= {RS_SIZE{1'b0}};
      issue_count_out <= 2'd0;
      no_issue_out    <= 1'b1;
      mem_busy_out    <= 1'b0;
      bad_fu_err_out  <= 1'b0;
      busy_cnt_r      <= {BUSY_W{1'b0}};
      for (int f = 0; f < FU_ARRAY; f++) begin
        rr_ptr_r[f] <= {RS_IDX{1'b0}};
      end
    end else if (flush_in) begin
      grant_valid_out <= {FU_ARRAY{1'b0}};
      grant_vec_out   <= {RS_SIZE{1'b0}};
      issue_count_out <= 2'd0;
      no_issue_out    <= 1'b1;
      mem_busy_out    <= 1'b0;
      busy_cnt_r      <= {BUSY_W{1'b0}};
    end else begin
      grant_valid_out <= sel_valid_s;
      grant_vec_out   <= sel_vec_s;
      issue_count_out <= count_ones(sel_valid_s);
      no_issue_out    <= (sel_valid_s == {FU_ARRAY{1'b0}});
      busy_cnt_r      <= busy_nxt_s;
      mem_busy_out    <= (busy_nxt_s != {BUSY_W{1'b0}});
      if (bad_s) begin
        bad_fu_err_out <= 1'b1;
      end
      for (int f = 0; f < FU_ARRAY; f++) begin
        if (sel_valid_s[f]) begin
          grant_idx_out[f*RS_IDX +: RS_IDX] <= sel_idx_s[f];
          rr_ptr_r[f]                       <= sel_idx_s[f] + RS_IDX'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed testbench for fu_issue_arbiter with hand-computed expectations.
module tb_fu_issue_arbiter;

  logic        clk;
  logic        rstn;
  logic [15:0] req_valid_in;
  logic [31:0] req_fu_in;
  logic [2:0]  fu_ready_from_FU_in;
  logic        flush_in;
  logic [2:0]  grant_valid_out;
  logic [11:0] grant_idx_out;
  logic [15:0] grant_vec_out;
  logic [1:0]  issue_count_out;
  logic        no_issue_out;
  logic        mem_busy_out;
  logic        bad_fu_err_out;

  int n_cmp;
  int n_err;

  fu_issue_arbiter dut (
    .clk                 (clk),
    .rstn                (rstn),
    .req_valid_in        (req_valid_in),
    .req_fu_in           (req_fu_in),
    .fu_ready_from_FU_in (fu_ready_from_FU_in),
    .flush_in            (flush_in),
    .grant_valid_out     (grant_valid_out),
    .grant_idx_out       (grant_idx_out),
    .grant_vec_out       (grant_vec_out),
    .issue_count_out     (issue_count_out),
    .no_issue_out        (no_issue_out),
    .mem_busy_out        (mem_busy_out),
    .bad_fu_err_out      (bad_fu_err_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int e, input logic [1:0] f);
    req_fu_in[e*2 +: 2] = f;
  endtask

  task automatic do_reset();
    req_valid_in        = 16'h0000;
    req_fu_in           = 32'h0000_0000;
    fu_ready_from_FU_in = 3'b111;
    flush_in            = 1'b0;
    rstn                = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Directed stimulus sequence.
  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();
    tick();

    // Reset state with no requests
    check_val("rst_valid", grant_valid_out, 3'b000);
    check_val("rst_idx",   grant_idx_out,   12'h000);
    check_val("rst_vec",   grant_vec_out,   16'h0000);
    check_val("rst_cnt",   issue_count_out, 2'd0);
    check_val("rst_noiss", no_issue_out,    1'b1);
    check_val("rst_busy",  mem_busy_out,    1'b0);
    check_val("rst_bad",   bad_fu_err_out,  1'b0);

    // Three FUs granted in parallel
    set_fu(3, 2'd0); set_fu(5, 2'd1); set_fu(9, 2'd2);
    req_valid_in = 16'h0228;
    tick();
    check_val("par_valid", grant_valid_out, 3'b111);
    check_val("par_idx",   grant_idx_out,   12'h953);
    check_val("par_vec",   grant_vec_out,   16'h0228);
    check_val("par_cnt",   issue_count_out, 2'd3);
    check_val("par_noiss", no_issue_out,    1'b0);
    check_val("par_busy",  mem_busy_out,    1'b1);
    tick();
    check_val("mask_valid", grant_valid_out, 3'b000);
    check_val("mask_cnt",   issue_count_out, 2'd0);
    check_val("mask_noiss", no_issue_out,    1'b1);
    check_val("mask_idx",   grant_idx_out,   12'h953);

    // FU0 round robin with wrap
    do_reset();
    set_fu(2, 2'd0); set_fu(6, 2'd0); set_fu(14, 2'd0);
    req_valid_in = 16'h4044;
    tick();
    check_val("rr_g2",  grant_idx_out[3:0], 4'd2);
    check_val("rr_v2",  grant_valid_out,    3'b001);
    req_valid_in[2] = 1'b0;
    tick();
    check_val("rr_g6",  grant_idx_out[3:0], 4'd6);
    req_valid_in[6] = 1'b0;
    tick();
    check_val("rr_g14", grant_idx_out[3:0], 4'd14);
    req_valid_in = 16'h0006;
    tick();
    check_val("rr_g1",  grant_idx_out[3:0], 4'd1);
    check_val("rr_v1",  grant_valid_out,    3'b001);
    req_valid_in = 16'h0004;
    tick();
    check_val("rr_g2b", grant_idx_out[3:0], 4'd2);
    check_val("rr_v2b", grant_valid_out,    3'b001);

    // Memory FU occupancy
    do_reset();
    set_fu(4, 2'd2); set_fu(7, 2'd2);
    req_valid_in = 16'h0090;
    tick();
    check_val("mem_g4",    grant_idx_out[11:8], 4'd4);
    check_val("mem_v4",    grant_valid_out,     3'b100);
    check_val("mem_busy1", mem_busy_out,        1'b1);
    req_valid_in = 16'h0080;
    tick();
    check_val("mem_busy2", mem_busy_out,        1'b1);
    check_val("mem_blk2",  grant_valid_out,     3'b000);
    tick();
    check_val("mem_busy3", mem_busy_out,        1'b0);
    check_val("mem_blk3",  grant_valid_out,     3'b000);
    tick();
    check_val("mem_v7",    grant_valid_out,     3'b100);
    check_val("mem_g7",    grant_idx_out[11:8], 4'd7);
    check_val("mem_busy4", mem_busy_out,        1'b1);

    // FU ready gating, then flush during memory occupancy
    do_reset();
    set_fu(0, 2'd0); set_fu(1, 2'd1); set_fu(9, 2'd1); set_fu(2, 2'd2);
    req_valid_in        = 16'h0207;
    fu_ready_from_FU_in = 3'b101;
    tick();
    check_val("rdy_valid", grant_valid_out,     3'b101);
    check_val("rdy_cnt",   issue_count_out,     2'd2);
    check_val("rdy_g0",    grant_idx_out[3:0],  4'd0);
    check_val("rdy_g2",    grant_idx_out[11:8], 4'd2);
    check_val("rdy_busy",  mem_busy_out,        1'b1);
    flush_in     = 1'b1;
    req_valid_in = 16'h0202;
    tick();
    check_val("fl_valid", grant_valid_out, 3'b000);
    check_val("fl_vec",   grant_vec_out,   16'h0000);
    check_val("fl_cnt",   issue_count_out, 2'd0);
    check_val("fl_noiss", no_issue_out,    1'b1);
    check_val("fl_busy",  mem_busy_out,    1'b0);
    flush_in            = 1'b0;
    fu_ready_from_FU_in = 3'b111;
    req_valid_in        = 16'h0206;
    tick();
    check_val("post_valid", grant_valid_out,    3'b110);
    check_val("post_g1",    grant_idx_out[7:4], 4'd1);
    check_val("post_g2",    grant_idx_out[11:8], 4'd2);
    check_val("post_cnt",   issue_count_out,    2'd2);

    // Out-of-range FU number
    do_reset();
    set_fu(0, 2'd3);
    req_valid_in = 16'h0001;
    tick();
    check_val("bad_valid", grant_valid_out, 3'b000);
    check_val("bad_set",   bad_fu_err_out,  1'b1);
    flush_in = 1'b1;
    tick();
    check_val("bad_flush", bad_fu_err_out,  1'b1);
    flush_in     = 1'b0;
    req_valid_in = 16'h0000;
    tick();
    check_val("bad_hold",  bad_fu_err_out,  1'b1);
    check_val("bad_nogr",  grant_valid_out, 3'b000);
    rstn = 1'b0;
    tick();
    check_val("bad_clr",   bad_fu_err_out,  1'b0);
    rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
